// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: single-cycle add/sub, iterative shift-add
// multiply and restoring divide, with Busy/Done/Err/Ovf status for the LEDs.
module calc_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic             Ovf,
  output logic [2:0]       State
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_EXEC = 3'b001;
  localparam logic [2:0] S_MUL  = 3'b010;
  localparam logic [2:0] S_DIV  = 3'b011;
  localparam logic [2:0] S_DONE = 3'b100;
  localparam logic [2:0] S_ERR  = 3'b101;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic               r_sub;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_c;
  logic [WIDTH-1:0]   r_r;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_ovf;

  logic               w_last;
  logic               w_iter;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_trial;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_nxt;

  assign w_iter = (r_state == S_MUL) || (r_state == S_DIV);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiplier: multiplicand added into the upper half, carry kept in the shift.
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Divider: remainder stays below B, so the shifted value fits in WIDTH+1 bits
  // and the trial MSB is a clean sign bit.
  assign w_div_sh    = {r_rem, r_quot[WIDTH-1]};
  assign w_div_trial = w_div_sh - {1'b0, r_b};
  assign w_div_ge    = ~w_div_trial[WIDTH];
  assign w_rem_nxt   = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_quot_nxt  = {r_quot[WIDTH-2:0], w_div_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            2'b10:   w_next = S_MUL;
            2'b11:   w_next = (B == '0) ? S_ERR : S_DIV;
            default: w_next = S_EXEC;
          endcase
        end
      end
      S_EXEC:  w_next = S_DONE;
      S_MUL:   w_next = w_last ? S_DONE : S_MUL;
      S_DIV:   w_next = w_last ? S_DONE : S_DIV;
      S_ERR:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (Abort) w_next = S_IDLE;
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_c     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_cnt   <= (w_iter && !w_last && !Abort) ? r_cnt + 1'b1 : '0;
      if (Abort) begin
        r_c   <= '0;
        r_r   <= '0;
        r_err <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_sub  <= Op[0];
              r_a    <= A;
              r_b    <= B;
              r_prod <= {{WIDTH{1'b0}}, B};
              r_rem  <= '0;
              r_quot <= A;
              r_c    <= '0;
              r_r    <= '0;
              r_err  <= 1'b0;
              r_ovf  <= 1'b0;
            end
          end
          S_EXEC: r_c <= r_sub ? ({1'b0, r_a} - {1'b0, r_b}) : ({1'b0, r_a} + {1'b0, r_b});
          S_MUL: begin
            r_prod <= w_prod_nxt;
            if (w_last) begin
              r_c   <= w_prod_nxt[WIDTH:0];
              r_ovf <= |w_prod_nxt[2*WIDTH-1:WIDTH+1];
            end
          end
          S_DIV: begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            if (w_last) begin
              r_c <= {1'b0, w_quot_nxt};
              r_r <= w_rem_nxt;
            end
          end
          S_ERR: begin
            r_err <= 1'b1;
            r_c   <= '0;
            r_r   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign C     = r_c;
  assign R     = r_r;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Err   = r_err;
  assign Ovf   = r_ovf;
  assign State = r_state;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: latency, results, status flags,
// busy rejection, abort and asynchronous reset.
module tb_calc_op_sequencer;

  logic        board_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [16:0] C;
  logic [15:0] R;
  logic        Busy, Done, Err, Ovf;
  logic [2:0]  State;

  int n_pass = 0;
  int n_total = 0;

  calc_op_sequencer #(.WIDTH(16)) dut (
    .board_clk(board_clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .Op(Op), .A(A), .B(B), .C(C), .R(R), .Busy(Busy), .Done(Done),
    .Err(Err), .Ovf(Ovf), .State(State)
  );

  always #5 board_clk = ~board_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  // Issues Start in cycle 0 and returns at cycle 1; operands are scrambled afterwards.
  task automatic do_start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    tick();
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0; A = 16'(~a); B = 16'(b + 16'h1357);
  endtask

  // Advances until Done or the bound; reports the Done cycle and whether Busy stayed high.
  task automatic wait_done(input int max, output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (1) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Done === 1'b1 || cyc >= max) break;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({C, R, Busy, Done, Err, Ovf, State} !== '0) begin
      $display("FAIL reset_outputs: got C=%h R=%h Busy=%b Done=%b Err=%b Ovf=%b State=%b, expected all 0",
               C, R, Busy, Done, Err, Ovf, State);
    end else n_pass++;
    tick(); tick();
    Reset = 1'b0;
  endtask

  task automatic test_addsub();
    int cyc; bit bok;
    do_start(2'b00, 16'hFFFF, 16'h0001);
    wait_done(10, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 2 || !bok) $display("FAIL add_latency: got cycle %0d busy_ok %0d, expected 2 1", cyc, bok);
    else n_pass++;
    n_total++;
    if (C !== 17'h10000 || Ovf !== 1'b0) $display("FAIL add_result: got C=%h Ovf=%b, expected 10000 0", C, Ovf);
    else n_pass++;
    tick();
    n_total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || State !== 3'b000 || C !== 17'h10000)
      $display("FAIL add_after_done: got Busy=%b Done=%b State=%b C=%h, expected 0 0 000 10000", Busy, Done, State, C);
    else n_pass++;
    do_start(2'b01, 16'h0003, 16'h0005);
    wait_done(10, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 2 || C !== 17'h1FFFE)
      $display("FAIL sub_borrow: got cycle %0d C=%h, expected 2 1fffe", cyc, C);
    else n_pass++;
  endtask

  task automatic test_mul();
    int cyc; bit bok;
    do_start(2'b10, 16'h0123, 16'h0045);
    wait_done(40, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 17 || !bok) $display("FAIL mul_latency: got cycle %0d busy_ok %0d, expected 17 1", cyc, bok);
    else n_pass++;
    n_total++;
    if (C !== 17'h04E6F || Ovf !== 1'b0 || R !== 16'h0) $display("FAIL mul_result: got C=%h Ovf=%b R=%h, expected 04e6f 0 0", C, Ovf, R);
    else n_pass++;
    tick();
    do_start(2'b10, 16'h1000, 16'h1000);
    wait_done(40, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 17 || C !== 17'h0 || Ovf !== 1'b1)
      $display("FAIL mul_overflow: got cycle %0d C=%h Ovf=%b, expected 17 0 1", cyc, C, Ovf);
    else n_pass++;
    repeat (4) tick();
    n_total++;
    if (Ovf !== 1'b1 || State !== 3'b000) $display("FAIL ovf_sticky: got Ovf=%b State=%b, expected 1 000", Ovf, State);
    else n_pass++;
  endtask

  task automatic test_div();
    int cyc; bit bok;
    do_start(2'b11, 16'd1000, 16'd7);
    wait_done(40, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 17 || !bok) $display("FAIL div_latency: got cycle %0d busy_ok %0d, expected 17 1", cyc, bok);
    else n_pass++;
    n_total++;
    if (C !== 17'd142 || R !== 16'd6 || Err !== 1'b0) $display("FAIL div_result: got C=%0d R=%0d Err=%b, expected 142 6 0", C, R, Err);
    else n_pass++;
    tick();
    do_start(2'b11, 16'd5, 16'd0);
    n_total++;
    if (State !== 3'b101) $display("FAIL div0_state: got State=%b, expected 101", State);
    else n_pass++;
    wait_done(10, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 2 || Err !== 1'b1 || C !== 17'h0 || R !== 16'h0)
      $display("FAIL div0_result: got cycle %0d Err=%b C=%h R=%h, expected 2 1 0 0", cyc, Err, C, R);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (Err !== 1'b1) $display("FAIL err_sticky: got Err=%b, expected 1", Err);
    else n_pass++;
    do_start(2'b00, 16'd1, 16'd2);
    n_total++;
    if (Err !== 1'b0) $display("FAIL err_clear: got Err=%b, expected 0", Err);
    else n_pass++;
    wait_done(10, cyc, bok);
    n_total++;
    if (C !== 17'd3 || cyc != 2) $display("FAIL add_after_err: got C=%0d cycle %0d, expected 3 2", C, cyc);
    else n_pass++;
    tick();
  endtask

  task automatic test_busy_reject();
    int ndone = 0;
    int dcyc = 0;
    do_start(2'b10, 16'd3, 16'd5);
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (Done === 1'b1) begin ndone++; dcyc = cyc; end
      Start = (cyc == 5);
      Op = (cyc == 5) ? 2'b00 : 2'b10;
      if (cyc == 17) begin
        n_total++;
        if (C !== 17'd15) $display("FAIL reject_result: got C=%0d, expected 15", C);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (ndone != 1 || dcyc != 17) $display("FAIL reject_done: got %0d pulses last at %0d, expected 1 at 17", ndone, dcyc);
    else n_pass++;
    n_total++;
    if (State !== 3'b000 || C !== 17'd15) $display("FAIL reject_idle: got State=%b C=%0d, expected 000 15", State, C);
    else n_pass++;
  endtask

  task automatic test_abort();
    int ndone = 0;
    do_start(2'b11, 16'd1000, 16'd7);
    repeat (7) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    n_total++;
    if (State !== 3'b000 || Busy !== 1'b0 || C !== 17'h0 || R !== 16'h0)
      $display("FAIL abort_idle: got State=%b Busy=%b C=%h R=%h, expected 000 0 0 0", State, Busy, C, R);
    else n_pass++;
    repeat (15) begin
      if (Done === 1'b1) ndone++;
      tick();
    end
    n_total++;
    if (ndone != 0) $display("FAIL abort_no_done: got %0d pulses, expected 0", ndone);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc; bit bok;
    int ndone = 0;
    do_start(2'b10, 16'h0123, 16'h0045);
    repeat (3) tick();
    n_total++;
    if (State !== 3'b010 || Busy !== 1'b1) $display("FAIL mul_running: got State=%b Busy=%b, expected 010 1", State, Busy);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++;
    if ({C, R, Busy, Done, Err, Ovf, State} !== '0)
      $display("FAIL reset_async: got C=%h R=%h Busy=%b Done=%b Err=%b Ovf=%b State=%b, expected all 0",
               C, R, Busy, Done, Err, Ovf, State);
    else n_pass++;
    tick(); tick();
    Reset = 1'b0;
    repeat (20) begin
      if (Done === 1'b1) ndone++;
      tick();
    end
    n_total++;
    if (ndone != 0 || State !== 3'b000) $display("FAIL reset_no_done: got %0d pulses State=%b, expected 0 000", ndone, State);
    else n_pass++;
    do_start(2'b10, 16'h0123, 16'h0045);
    wait_done(40, cyc, bok);
    n_total++;
    if (Done !== 1'b1 || cyc != 17 || C !== 17'h04E6F)
      $display("FAIL mul_after_reset: got cycle %0d C=%h, expected 17 04e6f", cyc, C);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_busy_reject();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
